// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode definitions for the ALU execute stage.
//   OP_W      - opcode width in bits
//   alu_op_e  - legal opcodes; 3'b110 and 3'b111 are undefined (illegal)
package alu_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_SLT  = 3'b100,
        OP_SLTU = 3'b101
    } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU datapath.
//   a, b      in   operands (two's complement)
//   op        in   opcode (alu_pkg::alu_op_e encoding)
//   result    out  ALU result, 0 for undefined opcodes
//   illegal   out  opcode is undefined
//   carry     out  adder carry-out for ADD/SUB, else 0   (only with ALU_FLAGS_EN)
//   overflow  out  signed overflow for ADD/SUB, else 0   (only with ALU_FLAGS_EN)
// Optional feature macro: ALU_FLAGS_EN.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] result,
    output logic             illegal
`ifdef ALU_FLAGS_EN
    ,
    output logic             carry,
    output logic             overflow
`endif
);

    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // One shared adder: ADD uses a+b, every compare/subtract uses a+~b+1.
    assign sub   = (op != OP_ADD);
    assign b_eff = sub ? ~b : b;
    assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

    // Signed overflow: operands (as seen by the adder) agree in sign, sum does not.
    assign ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (op)
            OP_ADD,
            OP_SUB:  result = sum;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            // a < b (signed) when the true difference is negative.
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
            // a < b (unsigned) when a + ~b + 1 produces no carry (borrow).
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, ~cout};
            default: illegal = 1'b1;
        endcase
    end

`ifdef ALU_FLAGS_EN
    always_comb begin
        carry    = 1'b0;
        overflow = 1'b0;
        if (op == OP_ADD || op == OP_SUB) begin
            carry    = cout;
            overflow = ovf;
        end
    end
`endif

endmodule

// File: rtl/alu_ex_stage.sv
// alu_ex_stage: one-deep registered ALU execute stage with valid/ready handshake.
//   clk, rst     clock (rising edge) and asynchronous active-high reset
//   in_valid     in   operand bundle present
//   in_ready     out  stage accepts a bundle this cycle
//   in_op/a/b    in   opcode and operands
//   out_valid    out  registered result present
//   out_ready    in   downstream consumes the result
//   out_result   out  registered result
//   out_illegal  out  registered result came from an undefined opcode
//   op_count     out  number of accepted bundles (wraps)
//   out_flags    out  {carry, overflow, zero}      (only with ALU_FLAGS_EN)
// Optional feature macro: ALU_FLAGS_EN.
module alu_ex_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_illegal,
    output logic [31:0]      op_count
`ifdef ALU_FLAGS_EN
    ,
    output logic [2:0]       out_flags
`endif
);

    logic [WIDTH-1:0] core_result;
    logic             core_illegal;
    logic             accept;

`ifdef ALU_FLAGS_EN
    logic core_carry;
    logic core_overflow;
`endif

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a        (in_a),
        .b        (in_b),
        .op       (in_op),
        .result   (core_result),
        .illegal  (core_illegal)
`ifdef ALU_FLAGS_EN
        ,
        .carry    (core_carry),
        .overflow (core_overflow)
`endif
    );

    // Register is free when empty or being drained this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_illegal <= 1'b0;
            op_count    <= '0;
        end else begin
            if (accept) begin
                out_valid   <= 1'b1;
                out_result  <= core_result;
                out_illegal <= core_illegal;
                op_count    <= op_count + 32'd1;
            end else if (out_ready) begin
                out_valid   <= 1'b0;
            end
        end
    end

`ifdef ALU_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_flags <= 3'b000;
        end else if (accept) begin
            out_flags <= {core_carry, core_overflow, (core_result == '0)};
        end
    end
`endif

endmodule

// File: tb/tb_alu_ex_stage.sv
module tb_alu_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_illegal;
    logic [31:0] op_count;
`ifdef ALU_FLAGS_EN
    logic [2:0]  out_flags;
`endif

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] exp_count = 32'd0;

    always #5 clk = ~clk;

    alu_ex_stage #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_illegal (out_illegal),
        .op_count    (op_count)
`ifdef ALU_FLAGS_EN
        ,
        .out_flags   (out_flags)
`endif
    );

    // Reference model: plain arithmetic from the opcode table.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd5: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_illegal(input logic [2:0] op);
        return (op > 3'd5);
    endfunction

    function automatic logic [2:0] ref_flags(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, s;
        logic   c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c  = 1'b0;
        v  = 1'b0;
        if (op == 3'd0) begin
            s = sa + sb;
            c = (({32'd0, a} + {32'd0, b}) > 64'h0000_0000_FFFF_FFFF);
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (op == 3'd1) begin
            s = sa - sb;
            c = (a >= b);
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        return {c, v, (ref_result(op, a, b) == 32'd0)};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_op     = 3'd0;
        in_a      = 32'd11;
        in_b      = 32'd22;
        out_ready = 1'b1;
        cycle();
        cycle();
        n_total++;
        if ({out_valid, out_illegal, out_result, op_count} !== 66'd0) begin
            $display("FAIL reset_state: got valid=%0b illegal=%0b result=%h count=%0d, want all 0",
                     out_valid, out_illegal, out_result, op_count);
        end else n_pass++;
`ifdef ALU_FLAGS_EN
        n_total++;
        if (out_flags !== 3'b000) $display("FAIL reset_flags: got %b want 000", out_flags);
        else n_pass++;
`endif
        in_valid = 1'b0;
        rst      = 1'b0;
        cycle();
        n_total++;
        if (out_valid !== 1'b0 || op_count !== 32'd0) begin
            $display("FAIL reset_idle: got valid=%0b count=%0d want 0/0", out_valid, op_count);
        end else n_pass++;
        exp_count = 32'd0;
    endtask

    task automatic test_directed();
        logic [2:0]  t_op [8] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd4, 3'd2, 3'd3, 3'd1};
        logic [31:0] t_a  [8] = '{32'h7FFFFFFF, 32'd5, 32'd5, 32'd5, 32'd5, 32'h0000F0F0, 32'h0000F0F0, 32'd7};
        logic [31:0] t_b  [8] = '{32'h00000001, 32'd7, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000FF00, 32'h0000FF00, 32'd7};
        logic [31:0] t_r  [8] = '{32'h80000000, 32'hFFFFFFFE, 32'd1, 32'd1, 32'd0, 32'h0000F000, 32'h0000FFF0, 32'd0};
        logic [2:0]  t_f  [8] = '{3'b010, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b101};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_op    = t_op[i];
            in_a     = t_a[i];
            in_b     = t_b[i];
            #1;
            n_total++;
            if (in_ready !== 1'b1) $display("FAIL directed_ready[%0d]: got %0b want 1", i, in_ready);
            else n_pass++;
            cycle();
            exp_count++;
            n_total++;
            if ({out_valid, out_illegal, out_result, op_count} !== {1'b1, 1'b0, t_r[i], exp_count}) begin
                $display("FAIL directed[%0d]: got valid=%0b illegal=%0b result=%h count=%0d, want 1/0/%h/%0d",
                         i, out_valid, out_illegal, out_result, op_count, t_r[i], exp_count);
            end else n_pass++;
`ifdef ALU_FLAGS_EN
            n_total++;
            if (out_flags !== t_f[i]) $display("FAIL directed_flags[%0d]: got %b want %b", i, out_flags, t_f[i]);
            else n_pass++;
`else
            if (t_f[i] === 3'bxxx) $display("unreachable");
`endif
        end
        in_valid = 1'b0;
        cycle();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL directed_drain: got valid=%0b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_op    = (i == 0) ? 3'b110 : 3'b111;
            in_a     = $urandom;
            in_b     = $urandom;
            cycle();
            exp_count++;
            n_total++;
            if ({out_valid, out_illegal, out_result, op_count} !== {1'b1, 1'b1, 32'd0, exp_count}) begin
                $display("FAIL illegal[%0d]: got valid=%0b illegal=%0b result=%h count=%0d, want 1/1/0/%0d",
                         i, out_valid, out_illegal, out_result, op_count, exp_count);
            end else n_pass++;
`ifdef ALU_FLAGS_EN
            n_total++;
            if (out_flags !== 3'b001) $display("FAIL illegal_flags[%0d]: got %b want 001", i, out_flags);
            else n_pass++;
`endif
        end
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 3'd0;
        in_a      = 32'd1;
        in_b      = 32'd2;
        cycle();
        exp_count++;
        in_a = 32'd10;
        in_b = 32'd20;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if ({in_ready, out_valid, out_result, op_count} !== {1'b0, 1'b1, 32'd3, exp_count}) begin
                $display("FAIL backpressure_hold[%0d]: got ready=%0b valid=%0b result=%0d count=%0d, want 0/1/3/%0d",
                         i, in_ready, out_valid, out_result, op_count, exp_count);
            end else n_pass++;
            cycle();
        end
        out_ready = 1'b1;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL backpressure_release_ready: got %0b want 1", in_ready);
        else n_pass++;
        cycle();
        exp_count++;
        n_total++;
        if ({out_valid, out_result, op_count} !== {1'b1, 32'd30, exp_count}) begin
            $display("FAIL backpressure_next: got valid=%0b result=%0d count=%0d, want 1/30/%0d",
                     out_valid, out_result, op_count, exp_count);
        end else n_pass++;
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_back_to_back();
        logic [2:0]  op;
        logic [31:0] a, b;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        exp_count = 32'd0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 10 == 0) ? ~a : $urandom;
            in_valid = 1'b1;
            in_op    = op;
            in_a     = a;
            in_b     = b;
            cycle();
            exp_count++;
            n_total++;
            if ({out_valid, out_illegal, out_result} !== {1'b1, 1'b0, ref_result(op, a, b)}) begin
                $display("FAIL back_to_back[%0d]: op=%0d a=%h b=%h got valid=%0b result=%h, want 1/%h",
                         i, op, a, b, out_valid, out_result, ref_result(op, a, b));
            end else n_pass++;
`ifdef ALU_FLAGS_EN
            n_total++;
            if (out_flags !== ref_flags(op, a, b))
                $display("FAIL back_to_back_flags[%0d]: got %b want %b", i, out_flags, ref_flags(op, a, b));
            else n_pass++;
`endif
        end
        in_valid = 1'b0;
        n_total++;
        if (op_count !== 32'd100) $display("FAIL back_to_back_count: got %0d want 100", op_count);
        else n_pass++;
        cycle();
    endtask

    // Random valid/ready traffic against a one-entry holding model.
    task automatic test_random_handshake();
        logic        m_valid = 1'b0;
        logic [31:0] m_res = 32'd0;
        logic        m_ill = 1'b0;
        logic [2:0]  m_flags = 3'd0;
        logic        acc;
        for (int i = 0; i < 200; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_op     = 3'($urandom_range(0, 7));
            in_a      = (i % 7 == 0) ? 32'h80000000 : $urandom;
            in_b      = (i % 5 == 0) ? 32'h00000001 : $urandom;
            #1;
            acc = in_valid && (!m_valid || out_ready);
            n_total++;
            if (in_ready !== (!m_valid || out_ready)) begin
                $display("FAIL handshake_ready[%0d]: got %0b want %0b", i, in_ready, (!m_valid || out_ready));
            end else n_pass++;
            if (acc) begin
                m_valid = 1'b1;
                m_res   = ref_result(in_op, in_a, in_b);
                m_ill   = ref_illegal(in_op);
                m_flags = ref_flags(in_op, in_a, in_b);
                exp_count++;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            cycle();
            n_total++;
            if (out_valid !== m_valid || op_count !== exp_count ||
                (m_valid && {out_illegal, out_result} !== {m_ill, m_res})) begin
                $display("FAIL handshake[%0d]: got valid=%0b illegal=%0b result=%h count=%0d, want %0b/%0b/%h/%0d",
                         i, out_valid, out_illegal, out_result, op_count, m_valid, m_ill, m_res, exp_count);
            end else n_pass++;
`ifdef ALU_FLAGS_EN
            if (m_valid) begin
                n_total++;
                if (out_flags !== m_flags) $display("FAIL handshake_flags[%0d]: got %b want %b", i, out_flags, m_flags);
                else n_pass++;
            end
`endif
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 3'd0;
        in_a      = 32'd9;
        in_b      = 32'd4;
        cycle();
        exp_count++;
        n_total++;
        if ({out_valid, out_result} !== {1'b1, 32'd13}) begin
            $display("FAIL async_setup: got valid=%0b result=%0d want 1/13", out_valid, out_result);
        end else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({out_valid, out_illegal, out_result, op_count} !== 66'd0) begin
            $display("FAIL async_reset: got valid=%0b illegal=%0b result=%h count=%0d, want all 0",
                     out_valid, out_illegal, out_result, op_count);
        end else n_pass++;
`ifdef ALU_FLAGS_EN
        n_total++;
        if (out_flags !== 3'b000) $display("FAIL async_reset_flags: got %b want 000", out_flags);
        else n_pass++;
`endif
        out_ready = 1'b1;
        cycle();
        cycle();
        n_total++;
        if (out_valid !== 1'b0 || op_count !== 32'd0) begin
            $display("FAIL reset_no_accept: got valid=%0b count=%0d want 0/0", out_valid, op_count);
        end else n_pass++;
        rst       = 1'b0;
        exp_count = 32'd0;
        in_a      = 32'd2;
        in_b      = 32'd2;
        cycle();
        exp_count++;
        n_total++;
        if ({out_valid, out_result, op_count} !== {1'b1, 32'd4, exp_count}) begin
            $display("FAIL reset_resume: got valid=%0b result=%0d count=%0d want 1/4/1",
                     out_valid, out_result, op_count);
        end else n_pass++;
        in_valid = 1'b0;
        cycle();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_random_handshake();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
